// File: rtl/serdes_tx_framer.sv
// Transmit framer: small byte FIFO feeding an LSB-first serial shifter, one sync byte per burst.
// Build option SERDES_TX_PARITY_EN appends an even-parity bit after every data byte.
module serdes_tx_framer #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [7:0]  SYNC_BYTE  = 8'hD5,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx_bit,
    output logic        tx_frame,
    output logic        byte_done,
    output logic [15:0] tx_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
`ifdef SERDES_TX_PARITY_EN
    localparam int unsigned BcW = 4;
    localparam logic [BcW-1:0] DataLast = 4'd8;
`else
    localparam int unsigned BcW = 3;
    localparam logic [BcW-1:0] DataLast = 3'd7;
`endif
    localparam logic [BcW-1:0] SyncLast = BcW'(7);

    typedef enum logic [1:0] {StIdle, StSync, StData} state_e;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, fifo_nonempty;
    logic [7:0]      head;

    state_e          state_q, state_d;
    logic [BcW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_bit_q, tx_bit_d;
    logic [15:0]     tx_count_q, tx_count_d;
    logic            last_bit;
`ifdef SERDES_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign in_ready      = (count_q != CntW'(DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign push          = in_valid && in_ready;
    assign head          = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign last_bit = (state_q == StSync) ? (bit_cnt_q == SyncLast) : (bit_cnt_q == DataLast);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + BcW'(1);
        shift_d    = {1'b0, shift_q[7:1]};
        tx_bit_d   = shift_q[0];
        tx_count_d = tx_count_q;
        pop        = 1'b0;
`ifdef SERDES_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                shift_d   = shift_q;
                tx_bit_d  = IDLE_LEVEL;
                if (fifo_nonempty) begin
                    state_d  = StSync;
                    shift_d  = {1'b0, SYNC_BYTE[7:1]};
                    tx_bit_d = SYNC_BYTE[0];
                end
            end
            StSync, StData: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if (state_q == StData) begin
                        tx_count_d = tx_count_q + 16'd1;
                    end
                    // Next byte follows with no gap cycle; sync only after idle.
                    if (fifo_nonempty) begin
                        pop      = 1'b1;
                        state_d  = StData;
                        shift_d  = {1'b0, head[7:1]};
                        tx_bit_d = head[0];
`ifdef SERDES_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d  = StIdle;
                        tx_bit_d = IDLE_LEVEL;
                    end
                end
`ifdef SERDES_TX_PARITY_EN
                else if (state_q == StData && bit_cnt_q == 4'd7) begin
                    tx_bit_d = parity_q;
                end
`endif
            end
            default: begin
                state_d  = StIdle;
                tx_bit_d = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_bit_q   <= IDLE_LEVEL;
            tx_count_q <= '0;
`ifdef SERDES_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_count_q <= tx_count_d;
`ifdef SERDES_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_bit    = tx_bit_q;
    assign tx_frame  = (state_q != StIdle);
    assign byte_done = (state_q == StData) && (bit_cnt_q == DataLast);
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Self-checking bench for serdes_tx_framer: queue-based line model compared every cycle,
// plus literal expectations for single-byte frames, back-to-back bursts and mid-byte reset.
`timescale 1ns/1ps
module tb_serdes_tx_framer;
    localparam int unsigned DEPTH = 2;
    localparam logic        IDLE  = 1'b0;
`ifdef SERDES_TX_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, tx_bit, tx_frame, byte_done;
    logic [15:0] tx_count;

    serdes_tx_framer #(
        .DEPTH      (DEPTH),
        .SYNC_BYTE  (8'hD5),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_bit    (tx_bit),
        .tx_frame  (tx_frame),
        .byte_done (byte_done),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int frame_cnt = 0;
    bit saw_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a byte queue, the current symbol as a queue of bits (front = on the line).
    logic [7:0]  m_fifo[$];
    logic        m_line[$];
    bit          m_active = 1'b0;
    bit          m_is_data = 1'b0;
    logic [15:0] m_count = 16'd0;
    int          m_pre;
    bit          m_push;
    logic [7:0]  m_byte;

    task automatic m_load(input logic [7:0] b, input bit data);
        m_line.delete();
        for (int i = 0; i < 8; i++) m_line.push_back(b[i]);
        if (data && Par == 1) m_line.push_back(^b);
        m_is_data = data;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_line.delete();
            m_active  = 1'b0;
            m_is_data = 1'b0;
            m_count   = 16'd0;
        end else begin
            m_pre  = m_fifo.size();
            m_push = in_valid && (m_pre < int'(DEPTH));
            if (!m_active) begin
                if (m_pre > 0) begin
                    m_load(8'hD5, 1'b0);
                    m_active = 1'b1;
                end
            end else begin
                void'(m_line.pop_front());
                if (m_line.size() == 0) begin
                    if (m_is_data) m_count = m_count + 16'd1;
                    if (m_pre > 0) begin
                        m_byte = m_fifo.pop_front();
                        m_load(m_byte, 1'b1);
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
            if (m_push) m_fifo.push_back(in_data);
        end
    end

    logic exp_bit;
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_bit = IDLE;
            if (m_active) exp_bit = m_line[0];
            check("tx_bit", 32'(tx_bit), 32'(exp_bit));
            check("tx_frame", 32'(tx_frame), 32'(m_active));
            check("byte_done", 32'(byte_done), 32'(m_active && m_is_data && m_line.size() == 1));
            check("in_ready", 32'(in_ready), 32'(m_fifo.size() < int'(DEPTH)));
            check("tx_count", 32'(tx_count), 32'(m_count));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (tx_frame) frame_cnt++;
        if (!in_ready) saw_full = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic run_single(input logic [7:0] b, input logic [16:0] exp_bits,
                              input logic [16:0] exp_done);
        logic [16:0] bits;
        logic [16:0] done;
        bits = '0;
        done = '0;
        send_byte(b);
        in_valid = 1'b0;
        check("single_pre_sync_frame", 32'(tx_frame), 32'd0);
        for (int i = 0; i < 16 + Par; i++) begin
            tick();
            bits[i] = tx_bit;
            done[i] = byte_done;
        end
        check("single_bits", 32'(bits), 32'(exp_bits));
        check("single_byte_done", 32'(done), 32'(exp_done));
        tick();
        check("single_idle_frame", 32'(tx_frame), 32'd0);
        check("single_idle_bit", 32'(tx_bit), 32'(IDLE));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int thresh;
    initial begin
        #7;
        cmp_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("idle_frame", 32'(tx_frame), 32'd0);
        check("idle_bit", 32'(tx_bit), 32'(IDLE));
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_count", 32'(tx_count), 32'd0);

        run_single(8'h3C, 17'h03CD5, (Par == 1) ? 17'h10000 : 17'h08000);
        check("count_after_3c", 32'(tx_count), 32'd1);
        run_single(8'h07, (Par == 1) ? 17'h107D5 : 17'h007D5, (Par == 1) ? 17'h10000 : 17'h08000);
        check("count_after_07", 32'(tx_count), 32'd2);

        frame_cnt = 0;
        saw_full  = 1'b0;
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'h12);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("burst_frames", 32'(frame_cnt), 32'(32 + 3 * Par));
        check("burst_saw_full", 32'(saw_full), 32'd1);
        check("burst_count", 32'(tx_count), 32'd5);

        send_byte(8'hA5);
        send_byte(8'hFF);
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("pre_reset_frame", 32'(tx_frame), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_bit", 32'(tx_bit), 32'(IDLE));
        check("reset_frame", 32'(tx_frame), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_count", 32'(tx_count), 32'd0);
        tick();
        rst = 1'b0;
        frame_cnt = 0;
        for (int i = 0; i < 20; i++) tick();
        check("no_resume_frames", 32'(frame_cnt), 32'd0);
        run_single(8'h12, 17'h012D5, (Par == 1) ? 17'h10000 : 17'h08000);
        check("count_after_reset", 32'(tx_count), 32'd1);

        thresh = 90;
        for (int c = 0; c < 3000; c++) begin
            if (rst) rst = 1'b0;
            if (c % 300 == 0) begin
                case ($urandom_range(3))
                    0:       thresh = 5;
                    1:       thresh = 30;
                    2:       thresh = 90;
                    default: thresh = 100;
                endcase
            end
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(99) < thresh);
                in_data  = 8'($urandom);
            end
            if ($urandom_range(599) == 0) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("drain_frame", 32'(tx_frame), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
